ps2_key_rx: RTL and testbench

//  PS/2 keyboard receiver and decoder. Feeds the VGA character-display stage.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_frame_rx.sv | 137 +++++++++++++
 rtl/ps2_key_rx.sv | 100 ++++++++++
 tb/tb_ps2_key_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM encoding and set-2 scan code to ASCII mapping
// for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // Set-2 make code to uppercase ASCII; anything unmapped yields 8'h00.
    function automatic logic [7:0] ascii(input logic [7:0] code);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
            8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
            8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
            8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
            8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
            8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, ps2_clk glitch filter,
// 11-bit frame FSM with odd-parity/stop checks and an inactivity timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       frame_done,
    output logic [7:0] code,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d, strobe_q, strobe_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          done_q, done_d, err_q, err_d;
    logic [7:0]    code_q, code_d;
    logic          tmo_hit;

    // Idle-high reset values keep the filter from seeing a false falling edge.
    always_comb begin
        clk_meta_d = ps2_clk;
        clk_sync_d = clk_meta_q;
        dat_meta_d = ps2_data;
        dat_sync_d = dat_meta_q;
        filt_d     = filt_q;
        fcnt_d     = '0;
        if (clk_sync_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q;
            else                               fcnt_d = fcnt_q + 1'b1;
        end
        strobe_d = filt_q & ~filt_d;
    end

    assign tmo_hit = (state_q != ST_IDLE) && !strobe_q && (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            strobe_q   <= 1'b0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= '0;
        end else begin
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            strobe_q   <= strobe_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        tmo_d     = '0;
        if (state_q != ST_IDLE && !strobe_q) tmo_d = tmo_q + 1'b1;
        if (tmo_hit) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
        end else if (strobe_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_ok_d = ^{shift_q, dat_sync_q};
                    state_d  = ST_STOP;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        done_d = 1'b0;
        err_d  = tmo_hit;
        code_d = code_q;
        if (strobe_q && state_q == ST_STOP) begin
            if (dat_sync_q && par_ok_q) begin
                done_d = 1'b1;
                code_d = shift_q;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign frame_done = done_q;
    assign code       = code_q;
    assign frame_err  = err_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver top: frame reception plus make/break/extended decoding
// into a held-key ASCII code for the character display.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2_byte,
    output logic       ps2_state,
    output logic [7:0] scan_code,
    output logic       key_valid,
    output logic       frame_err
);

    logic       rx_done, rx_err;
    logic [7:0] rx_code;

    logic [7:0] byte_q, byte_d, scan_q, scan_d;
    logic       state_q, state_d, kv_q, kv_d, err_q, err_d;
    logic       brk_q, brk_d, ext_q, ext_d;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_frame_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .frame_done(rx_done),
        .code      (rx_code),
        .frame_err (rx_err)
    );

    always_comb begin
        byte_d  = byte_q;
        scan_d  = scan_q;
        state_d = state_q;
        kv_d    = 1'b0;
        err_d   = rx_err;
        brk_d   = brk_q;
        ext_d   = ext_q;
        if (rx_err) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (rx_done) begin
            if (rx_code == PS2_BRK) begin
                brk_d = 1'b1;
            end else if (rx_code == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (brk_q) begin
                // Releases of keys other than the held one are dropped.
                if (rx_code == scan_q) begin
                    state_d = 1'b0;
                    byte_d  = 8'h00;
                end
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                scan_d  = rx_code;
                state_d = 1'b1;
                kv_d    = 1'b1;
                byte_d  = ext_q ? 8'h00 : ascii(rx_code);
                ext_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q  <= '0;
            scan_q  <= '0;
            state_q <= 1'b0;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            byte_q  <= byte_d;
            scan_q  <= scan_d;
            state_q <= state_d;
            kv_q    <= kv_d;
            err_q   <= err_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
        end
    end

    assign ps2_byte  = byte_q;
    assign ps2_state = state_q;
    assign scan_code = scan_q;
    assign key_valid = kv_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: directed frame table, glitch/timeout/reset sequences,
// then random frames against a behavioural keyboard model.
module tb_ps2_key_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 500;
    localparam int HALF        = 20;
    localparam int GAP         = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ps2_byte, scan_code;
    logic       ps2_state, key_valid, frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int kv_cnt   = 0;
    int fe_cnt   = 0;

    ps2_key_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_byte (ps2_byte),
        .ps2_state(ps2_state),
        .scan_code(scan_code),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (frame_err) fe_cnt++;
    end

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        int         kv;
        int         fe;
        logic [7:0] exp_byte;
        bit         exp_state;
        logic [7:0] exp_scan;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = code;
        bits[9]   = (~^code) ^ bad_par;
        bits[10]  = ~bad_stop;
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic do_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst_n    = 1'b0;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(4);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] b, input bit s, input logic [7:0] sc);
        check({tag, ".byte"},  {24'd0, ps2_byte}, {24'd0, b});
        check({tag, ".state"}, {31'd0, ps2_state}, {31'd0, s});
        check({tag, ".scan"},  {24'd0, scan_code}, {24'd0, sc});
    endtask

    // Model ASCII lookup built from the keyboard legend rather than a case table.
    function automatic logic [7:0] model_ascii(input logic [7:0] c);
        string      legend = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
        logic [7:0] keys[36] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                                 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46};
        for (int i = 0; i < 36; i++) if (keys[i] == c) return legend[i];
        if (c == 8'h29) return " ";
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    initial begin
        int kv0, fe0;
        logic [7:0] pool[12] = '{8'hF0, 8'hF0, 8'hE0, 8'h1C, 8'h32, 8'h75, 8'h29,
                                 8'h5A, 8'h45, 8'h77, 8'h66, 8'h1A};
        logic [7:0] m_held, m_byte, c;
        bit         m_state, m_brk, m_ext, bad;
        int         exp_kv, exp_fe;

        do_reset();
        check_outs("reset", 8'h00, 1'b0, 8'h00);
        check("reset.key_valid", {31'd0, key_valid}, 32'd0);
        check("reset.frame_err", {31'd0, frame_err}, 32'd0);

        tbl.push_back('{8'h1C, 0, 0, 1, 0, 8'h41, 1, 8'h1C});
        tbl.push_back('{8'hF0, 0, 0, 0, 0, 8'h41, 1, 8'h1C});
        tbl.push_back('{8'h1C, 0, 0, 0, 0, 8'h00, 0, 8'h1C});
        tbl.push_back('{8'h1C, 1, 0, 0, 1, 8'h00, 0, 8'h1C});
        tbl.push_back('{8'hE0, 0, 0, 0, 0, 8'h00, 0, 8'h1C});
        tbl.push_back('{8'h75, 0, 0, 1, 0, 8'h00, 1, 8'h75});
        tbl.push_back('{8'h32, 0, 0, 1, 0, 8'h42, 1, 8'h32});
        tbl.push_back('{8'h32, 0, 0, 1, 0, 8'h42, 1, 8'h32});
        tbl.push_back('{8'h1C, 0, 0, 1, 0, 8'h41, 1, 8'h1C});
        tbl.push_back('{8'hF0, 0, 0, 0, 0, 8'h41, 1, 8'h1C});
        tbl.push_back('{8'h32, 0, 0, 0, 0, 8'h41, 1, 8'h1C});
        tbl.push_back('{8'h45, 0, 1, 0, 1, 8'h41, 1, 8'h1C});
        tbl.push_back('{8'hF0, 0, 0, 0, 0, 8'h41, 1, 8'h1C});
        tbl.push_back('{8'h1C, 0, 0, 0, 0, 8'h00, 0, 8'h1C});
        tbl.push_back('{8'hF0, 0, 0, 0, 0, 8'h00, 0, 8'h1C});
        tbl.push_back('{8'h29, 1, 0, 0, 1, 8'h00, 0, 8'h1C});
        tbl.push_back('{8'h29, 0, 0, 1, 0, 8'h20, 1, 8'h29});

        foreach (tbl[i]) begin
            kv0 = kv_cnt;
            fe0 = fe_cnt;
            send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop);
            check($sformatf("vec%0d.kv", i), kv_cnt - kv0, tbl[i].kv);
            check($sformatf("vec%0d.fe", i), fe_cnt - fe0, tbl[i].fe);
            check_outs($sformatf("vec%0d", i), tbl[i].exp_byte, tbl[i].exp_state, tbl[i].exp_scan);
        end

        // Short ps2_clk low glitch with data low: a false start bit would time out.
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        ps2_data = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(FILTER_LEN - 2);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        ps2_data = 1'b1;
        wait_cyc(TIMEOUT_CYC + 100);
        check("glitch.fe", fe_cnt - fe0, 0);
        check("glitch.kv", kv_cnt - kv0, 0);
        check_outs("glitch", 8'h20, 1'b1, 8'h29);

        // Start bit plus four bits, then silence.
        fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(TIMEOUT_CYC - 100);
        check("timeout.early", fe_cnt - fe0, 0);
        wait_cyc(150);
        check("timeout.fe", fe_cnt - fe0, 1);
        check_outs("timeout", 8'h20, 1'b1, 8'h29);
        send_frame(8'h32, 0, 0);
        check_outs("after_timeout", 8'h42, 1'b1, 8'h32);

        // Reset in the middle of a frame.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        wait_cyc(3);
        check_outs("midreset", 8'h00, 1'b0, 8'h00);
        check("midreset.kv", {31'd0, key_valid}, 32'd0);
        do_reset();
        kv0 = kv_cnt;
        send_frame(8'h1C, 0, 0);
        check("post_reset.kv", kv_cnt - kv0, 1);
        check_outs("post_reset", 8'h41, 1'b1, 8'h1C);

        // Random frames against the behavioural model.
        do_reset();
        m_held = 8'h00; m_byte = 8'h00; m_state = 0; m_brk = 0; m_ext = 0;
        for (int n = 0; n < 40; n++) begin
            c   = pool[$urandom_range(0, 11)];
            bad = ($urandom_range(0, 7) == 0);
            exp_kv = 0;
            exp_fe = 0;
            if (bad) begin
                exp_fe = 1;
                m_brk  = 0;
                m_ext  = 0;
            end else if (c == 8'hF0) begin
                m_brk = 1;
            end else if (c == 8'hE0) begin
                m_ext = 1;
            end else if (m_brk) begin
                if (c == m_held) begin
                    m_state = 0;
                    m_byte  = 8'h00;
                end
                m_brk = 0;
                m_ext = 0;
            end else begin
                m_held  = c;
                m_state = 1;
                m_byte  = m_ext ? 8'h00 : model_ascii(c);
                m_ext   = 0;
                exp_kv  = 1;
            end
            kv0 = kv_cnt;
            fe0 = fe_cnt;
            send_frame(c, bad, 0);
            check($sformatf("rnd%0d.kv", n), kv_cnt - kv0, exp_kv);
            check($sformatf("rnd%0d.fe", n), fe_cnt - fe0, exp_fe);
            check_outs($sformatf("rnd%0d", n), m_byte, m_state, m_held);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
